uart_autobaud: RTL and testbench

- Configuration controller for the UART baud generator.
- On request, it measures one received sync character 0x55 ('U', 8N1, LSB first) on the RX line and computes the 16-bit divisor.
- The generator's x16 tick period equals the divisor in clock cycles, so one bit time = 16 × divisor.
- Drives the generator's divisor input directly; software or the UART front-end issues a start pulse and reads status.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync_edge.sv | 39 +++
 rtl/uart_autobaud.sv | 200 ++++++++++++++++++++
 tb/tb_uart_autobaud.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART auto-baud controller and receiver helpers.
package uart_pkg;

   // Controller state encoding
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_IDLE  = 3'd1,
      S_WAIT_START = 3'd2,
      S_MEASURE    = 3'd3,
      S_CHECK      = 3'd4
   } state_e;

   // Falling edges after the start edge that close the measured window
   localparam int SYNC_FALL_EDGES = 4;
   // Bit times spanned by the measured window
   localparam int SYNC_BIT_TIMES  = 8;
   // Window length is 16 ticks per bit times 8 bits, so divide by 128 (shift 7)
   localparam int DIV_SHIFT       = $clog2(16 * SYNC_BIT_TIMES);
   // Half of the divide step, for round-to-nearest
   localparam int DIV_ROUND       = 1 << (DIV_SHIFT - 1);
   // Smallest divisor the baud generator can run with
   localparam int MIN_DIVISOR     = 2;

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchroniser for the raw RX line plus rising/falling edge detection.
module uart_rx_sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic rxd,
   output logic rxdSync,
   output logic riseEdge,
   output logic fallEdge
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   // Shift the raw line through the synchroniser and keep the previous synced sample
   always_comb begin
      meta_d = rxd;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // Synchroniser and history flops; all idle-high out of reset so no edge fires
   always_ff @(posedge clock) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rxdSync  = sync_q;
   assign riseEdge = sync_q & ~prev_q;
   assign fallEdge = ~sync_q & prev_q;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud controller: times a received 0x55 sync character and derives the
// x16 baud generator divisor from the span of 8 bit times.
module uart_autobaud
   import uart_pkg::*;
#(
   parameter int          IDLE_CYCLES     = 1024,
   parameter logic [15:0] DEFAULT_DIVISOR = 16'd27,
   parameter int          CNT_WIDTH       = 24
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rxd,
   input  logic        start,
   input  logic        abort,
   output logic [15:0] baudDivisor,
   output logic        divisorValid,
   output logic        busy,
   output logic        error
);

   localparam int CW = CNT_WIDTH;
   localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   // Wide enough to hold the rounded quotient and to see values above 16 bits
   localparam int DW = (CNT_WIDTH + 1 > 17) ? CNT_WIDTH + 1 : 17;

   state_e          state_q, state_d;
   logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
   logic [CW-1:0]   total_cnt_q, total_cnt_d;
   logic [CW-1:0]   seg_cnt_q, seg_cnt_d;
   logic [CW-1:0]   start_len_q, start_len_d;
   logic [CW-1:0]   t_q, t_d;
   logic [2:0]      fall_cnt_q, fall_cnt_d;
   logic            first_seg_q, first_seg_d;
   logic [15:0]     div_q, div_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            error_q, error_d;

   logic            rxd_sync_s, rise_s, fall_s, edge_s;
   logic [CW-1:0]   seg_len_s;
   logic            seg_bad_s;
   logic [DW-1:0]   sum_s, d_full_s;
   logic            d_bad_s;

   uart_rx_sync_edge u_sync (
      .clock    (clock),
      .reset    (reset),
      .rxd      (rxd),
      .rxdSync  (rxd_sync_s),
      .riseEdge (rise_s),
      .fallEdge (fall_s)
   );

   assign edge_s    = rise_s | fall_s;
   assign seg_len_s = seg_cnt_q + CW'(1'b1);
   // A segment is rejected if it is under half or over twice the start bit
   assign seg_bad_s = ({seg_len_s, 1'b0} < {1'b0, start_len_q}) ||
                      ({1'b0, seg_len_s} > {start_len_q, 1'b0});
   assign sum_s     = DW'(t_q) + DW'(DIV_ROUND);
   assign d_full_s  = sum_s >> DIV_SHIFT;
   assign d_bad_s   = (d_full_s < DW'(MIN_DIVISOR)) || (d_full_s > DW'(17'h0_FFFF));

   // Next-state, counter and output logic for the detection sequence
   always_comb begin
      state_d     = state_q;
      idle_cnt_d  = idle_cnt_q;
      total_cnt_d = total_cnt_q;
      seg_cnt_d   = seg_cnt_q;
      start_len_d = start_len_q;
      t_d         = t_q;
      fall_cnt_d  = fall_cnt_q;
      first_seg_d = first_seg_q;
      div_d       = div_q;
      valid_d     = 1'b0;
      error_d     = error_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_WAIT_IDLE;
               error_d    = 1'b0;
               idle_cnt_d = {IW{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (!rxd_sync_s) begin
               idle_cnt_d = {IW{1'b0}};
            end else if (idle_cnt_q == IW'(IDLE_CYCLES - 1)) begin
               state_d = S_WAIT_START;
            end else begin
               idle_cnt_d = idle_cnt_q + IW'(1'b1);
            end
         end
         S_WAIT_START: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (fall_s) begin
               state_d     = S_MEASURE;
               total_cnt_d = {CW{1'b0}};
               seg_cnt_d   = {CW{1'b0}};
               fall_cnt_d  = 3'd0;
               start_len_d = {CW{1'b0}};
               first_seg_d = 1'b1;
            end else begin
               state_d = S_WAIT_START;
            end
         end
         S_MEASURE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (total_cnt_q == {CW{1'b1}}) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               total_cnt_d = total_cnt_q + CW'(1'b1);
               seg_cnt_d   = seg_cnt_q + CW'(1'b1);
               if (edge_s) begin
                  seg_cnt_d = {CW{1'b0}};
                  if (first_seg_q) begin
                     start_len_d = seg_len_s;
                     first_seg_d = 1'b0;
                  end else if (seg_bad_s) begin
                     error_d = 1'b1;
                     state_d = S_IDLE;
                  end else if (fall_s) begin
                     fall_cnt_d = fall_cnt_q + 3'd1;
                     if (fall_cnt_q == 3'(SYNC_FALL_EDGES - 1)) begin
                        t_d     = total_cnt_q + CW'(1'b1);
                        state_d = S_CHECK;
                     end else begin
                        state_d = S_MEASURE;
                     end
                  end else begin
                     state_d = S_MEASURE;
                  end
               end else begin
                  state_d = S_MEASURE;
               end
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
            if (abort) begin
               div_d = div_q;
            end else if (d_bad_s) begin
               error_d = 1'b1;
            end else begin
               div_d   = d_full_s[15:0];
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idle_cnt_q  <= {IW{1'b0}};
         total_cnt_q <= {CW{1'b0}};
         seg_cnt_q   <= {CW{1'b0}};
         start_len_q <= {CW{1'b0}};
         t_q         <= {CW{1'b0}};
         fall_cnt_q  <= 3'd0;
         first_seg_q <= 1'b1;
         div_q       <= DEFAULT_DIVISOR;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idle_cnt_q  <= idle_cnt_d;
         total_cnt_q <= total_cnt_d;
         seg_cnt_q   <= seg_cnt_d;
         start_len_q <= start_len_d;
         t_q         <= t_d;
         fall_cnt_q  <= fall_cnt_d;
         first_seg_q <= first_seg_d;
         div_q       <= div_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         error_q     <= error_d;
      end
   end

   assign baudDivisor  = div_q;
   assign divisorValid = valid_q;
   assign busy         = busy_q;
   assign error        = error_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: scoreboard of expected divisors plus
// per-scenario flag checks.
module tb_uart_autobaud;

   localparam int IDLE_CYC = 1024;
   localparam int CW       = 14;   // small counter so the overflow case stays short

   logic        clock = 1'b0;
   logic        reset, rxd, start, abort;
   logic [15:0] baudDivisor;
   logic        divisorValid, busy, error;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          valid_seen = 0;
   int          cyc = 0;
   int          b7_cyc = 0;
   int          valid_cyc = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;

   uart_autobaud #(
      .IDLE_CYCLES     (IDLE_CYC),
      .DEFAULT_DIVISOR (16'd27),
      .CNT_WIDTH       (CW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .rxd          (rxd),
      .start        (start),
      .abort        (abort),
      .baudDivisor  (baudDivisor),
      .divisorValid (divisorValid),
      .busy         (busy),
      .error        (error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard: every valid pulse must match the oldest expected divisor
   always @(negedge clock) begin
      if (divisorValid === 1'b1) begin
         valid_seen = valid_seen + 1;
         valid_cyc  = cyc;
         n_cmp      = n_cmp + 1;
         if (exp_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL sb_unexpected: got divisor %0d with valid, expected no update", baudDivisor);
         end else begin
            mon_exp = exp_q.pop_front();
            if (baudDivisor !== mon_exp) begin
               n_bad = n_bad + 1;
               $display("FAIL sb_divisor: got %0d, expected %0d", baudDivisor, mon_exp);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // Divisor the baud generator needs for a given bit period; 0 means reject
   function automatic int model_div(input int period);
      int d;
      d = (8 * period + 64) >> 7;
      if (d < 2 || d > 65535) model_div = 0;
      else model_div = d;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      rxd = v;
      wait_cyc(n);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      wait_cyc(1);
      start = 1'b0;
   endtask

   task automatic arm();
      pulse_start();
      hold(1'b1, IDLE_CYC + 16);
   endtask

   // 0x55 framed 8N1, optional low glitch inside bit 0
   task automatic send_char(input int period, input int gl_off, input int gl_len);
      logic [7:0] ch;
      ch = 8'h55;
      hold(1'b0, period);
      for (int b = 0; b < 8; b++) begin
         if (b == 7) b7_cyc = cyc;
         if (b == 0 && gl_len > 0) begin
            hold(1'b1, gl_off);
            hold(1'b0, gl_len);
            hold(1'b1, period - gl_off - gl_len);
         end else begin
            hold(ch[b], period);
         end
      end
      hold(1'b1, period);
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         wait_cyc(1);
      end
      if (!ok) exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; rxd = 1'b1; start = 1'b0; abort = 1'b0;
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(1);
      n_cmp++; if (baudDivisor !== 16'd27) begin n_bad++; $display("FAIL reset_div: got %0d, expected 27", baudDivisor); end
      n_cmp++; if (divisorValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, expected 0", divisorValid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b, expected 0", error); end
   endtask

   task automatic test_nominal();
      int v0; bit ok;
      v0 = valid_seen;
      exp_q.push_back(16'(model_div(432)));
      arm();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nom_busy_armed: got %b, expected 1", busy); end
      send_char(432, 0, 0);
      wait_drain(20, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL nom_drain: got no divisor update, expected 27"); end
      n_cmp++; if (valid_seen - v0 !== 1) begin n_bad++; $display("FAIL nom_pulses: got %0d, expected 1", valid_seen - v0); end
      n_cmp++; if (valid_cyc - b7_cyc !== 4) begin n_bad++; $display("FAIL nom_latency: got %0d, expected 4", valid_cyc - b7_cyc); end
      n_cmp++; if (baudDivisor !== 16'd27) begin n_bad++; $display("FAIL nom_div: got %0d, expected 27", baudDivisor); end
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL nom_error: got %b, expected 0", error); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nom_busy: got %b, expected 0", busy); end
   endtask

   task automatic test_fast_limit();
      int v0; bit ok;
      // 32-cycle bits give the smallest legal divisor
      v0 = valid_seen;
      exp_q.push_back(16'(model_div(32)));
      arm();
      send_char(32, 0, 0);
      wait_drain(20, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL fast_drain: got no divisor update, expected 2"); end
      n_cmp++; if (valid_seen - v0 !== 1) begin n_bad++; $display("FAIL fast_pulses: got %0d, expected 1", valid_seen - v0); end
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL fast_error: got %b, expected 0", error); end
      // 16-cycle bits round to divisor 1: rejected
      v0 = valid_seen;
      n_cmp++; if (model_div(16) !== 0) begin n_bad++; $display("FAIL fast_model: got %0d, expected 0", model_div(16)); end
      arm();
      send_char(16, 0, 0);
      wait_cyc(10);
      n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL slow_error: got %b, expected 1", error); end
      n_cmp++; if (baudDivisor !== 16'd2) begin n_bad++; $display("FAIL slow_div: got %0d, expected 2", baudDivisor); end
      n_cmp++; if (valid_seen - v0 !== 0) begin n_bad++; $display("FAIL slow_pulses: got %0d, expected 0", valid_seen - v0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL slow_busy: got %b, expected 0", busy); end
   endtask

   task automatic test_glitch();
      int v0;
      v0 = valid_seen;
      arm();
      send_char(432, 200, 20);
      wait_cyc(10);
      n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL glitch_error: got %b, expected 1", error); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy: got %b, expected 0", busy); end
      n_cmp++; if (baudDivisor !== 16'd2) begin n_bad++; $display("FAIL glitch_div: got %0d, expected 2", baudDivisor); end
      n_cmp++; if (valid_seen - v0 !== 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d, expected 0", valid_seen - v0); end
   endtask

   task automatic test_reset_mid();
      arm();
      hold(1'b0, 432);
      hold(1'b1, 100);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_pre: got %b, expected 1", busy); end
      reset = 1'b1;
      wait_cyc(1);
      reset = 1'b0;
      n_cmp++; if (baudDivisor !== 16'd27) begin n_bad++; $display("FAIL rstmid_div: got %0d, expected 27", baudDivisor); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rstmid_error: got %b, expected 0", error); end
      n_cmp++; if (divisorValid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b, expected 0", divisorValid); end
      hold(1'b1, 2000);
   endtask

   task automatic test_idle_gating();
      int v0; bit ok;
      v0 = valid_seen;
      rxd = 1'b0;
      pulse_start();
      hold(1'b0, 500);
      hold(1'b1, 600);
      // Line has not been idle long enough: this character must be ignored
      send_char(200, 0, 0);
      hold(1'b1, IDLE_CYC + 16);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL idle_busy: got %b, expected 1", busy); end
      exp_q.push_back(16'(model_div(432)));
      send_char(432, 0, 0);
      wait_drain(20, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL idle_drain: got no divisor update, expected 27"); end
      n_cmp++; if (valid_seen - v0 !== 1) begin n_bad++; $display("FAIL idle_pulses: got %0d, expected 1", valid_seen - v0); end
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL idle_error: got %b, expected 0", error); end
   endtask

   task automatic test_start_while_busy();
      int v0; bit ok;
      v0 = valid_seen;
      exp_q.push_back(16'(model_div(64)));
      arm();
      pulse_start();
      fork
         send_char(64, 0, 0);
         begin
            wait_cyc(200);
            pulse_start();
         end
      join
      wait_drain(20, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL busy_drain: got no divisor update, expected 4"); end
      n_cmp++; if (valid_seen - v0 !== 1) begin n_bad++; $display("FAIL busy_pulses: got %0d, expected 1", valid_seen - v0); end
      n_cmp++; if (baudDivisor !== 16'd4) begin n_bad++; $display("FAIL busy_div: got %0d, expected 4", baudDivisor); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_end: got %b, expected 0", busy); end
   endtask

   task automatic test_abort();
      int v0;
      v0 = valid_seen;
      arm();
      hold(1'b0, 432);
      hold(1'b1, 100);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_pre: got %b, expected 1", busy); end
      abort = 1'b1;
      wait_cyc(1);
      abort = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b, expected 0", busy); end
      hold(1'b1, 332);
      for (int i = 0; i < 3; i++) begin
         hold(1'b0, 432);
         hold(1'b1, 432);
      end
      hold(1'b1, 1000);
      n_cmp++; if (valid_seen - v0 !== 0) begin n_bad++; $display("FAIL abort_pulses: got %0d, expected 0", valid_seen - v0); end
      n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL abort_error: got %b, expected 0", error); end
      n_cmp++; if (baudDivisor !== 16'd4) begin n_bad++; $display("FAIL abort_div: got %0d, expected 4", baudDivisor); end
   endtask

   task automatic test_overflow();
      int v0;
      v0 = valid_seen;
      arm();
      hold(1'b0, 50);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ovf_busy_pre: got %b, expected 1", busy); end
      hold(1'b0, (1 << CW) + 100);
      n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL ovf_error: got %b, expected 1", error); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf_busy: got %b, expected 0", busy); end
      n_cmp++; if (valid_seen - v0 !== 0) begin n_bad++; $display("FAIL ovf_pulses: got %0d, expected 0", valid_seen - v0); end
      hold(1'b1, 50);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_fast_limit();
      test_glitch();
      test_reset_mid();
      test_idle_gating();
      test_start_while_busy();
      test_abort();
      test_overflow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
